// File: rtl/pkt_cache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pkt_cache_pkg                                                              |
// | Shared definitions for the packet cache: cell tag encodings, read-engine   |
// | state type and default geometry.                                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pkt_cache_pkg;

  localparam int DEF_DATA_W   = 134;
  localparam int DEF_SLOT_NUM = 32;
  localparam int DEF_CELL_NUM = 128;

  // Cell tag carried in the two MSBs of every cell
  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] MID  = 2'b11;
  localparam logic [1:0] TAIL = 2'b10;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_RD   = 2'd1,
    RD_LAST = 2'd2
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/pkt_cache_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pkt_cache_ram                                                              |
// | Simple dual-port cell store, one write port and one read port with a       |
// | registered (1-cycle) read.                                                 |
// | Ports: clk; wr_en_i/wr_addr_i/wr_data_i write port;                        |
// |        rd_addr_i in, rd_data_o out (data for the address of last cycle).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pkt_cache_ram #(
  parameter int DATA_W = 134,
  parameter int DEPTH  = 4096,
  parameter int AW     = 12
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/pkt_cache.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pkt_cache                                                                  |
// | Packet cache: stores incoming cell streams into per-packet slots, announces|
// | committed slot IDs, and replays a slot's cells on request.                 |
// | Ports: clk, rst (async, active-high)                                       |
// |   in_data_wr/in_data       input cells (tag in two MSBs)                   |
// |   in_valid_wr/in_valid     end-of-packet verdict (1 keep, 0 drop)          |
// |   in_ref                   reference count (PKT_CACHE_MCAST_EN only)       |
// |   out_id_wr/out_id         committed slot announcement                     |
// |   out_free_cnt             number of free slots                            |
// |   in_id_wr/in_id/in_id_rdy read request for a committed slot              |
// |   out_data_wr/out_data     replayed cells                                  |
// |   out_valid_wr/out_valid   end-of-read strobe                              |
// |   out_drop_cnt             saturating dropped-packet count                 |
// | Build option: PKT_CACHE_MCAST_EN adds per-slot reference counting.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pkt_cache
  import pkt_cache_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SLOT_NUM = DEF_SLOT_NUM,
  parameter int CELL_NUM = DEF_CELL_NUM,
  parameter int ID_W     = $clog2(SLOT_NUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_data_wr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid_wr,
  input  logic              in_valid,
`ifdef PKT_CACHE_MCAST_EN
  input  logic [3:0]        in_ref,
`endif
  output logic              out_id_wr,
  output logic [ID_W-1:0]   out_id,
  output logic [ID_W:0]     out_free_cnt,
  input  logic              in_id_wr,
  input  logic [ID_W-1:0]   in_id,
  output logic              in_id_rdy,
  output logic              out_data_wr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid_wr,
  output logic              out_valid,
  output logic [15:0]       out_drop_cnt
);

  localparam int OW = $clog2(CELL_NUM);
  localparam int CW = OW + 1;
  localparam int AW = ID_W + OW;

  // Slot bookkeeping
  logic [SLOT_NUM-1:0] free_q, free_d, commit_q, commit_d;
  logic [SLOT_NUM-1:0] w_rel_mask, w_alloc_mask;
  logic [CW-1:0]       len_q [SLOT_NUM];

  // Write context of the packet currently being received
  logic            open_q, open_d, tail_seen_q, tail_seen_d;
  logic            has_slot_q, has_slot_d, ovf_q, ovf_d;
  logic [ID_W-1:0] wr_id_q, wr_id_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic            id_wr_q, id_wr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [15:0]     drop_q, drop_d;

  // Read engine
  rd_state_e       state_q, state_d;
  logic [ID_W-1:0] rd_id_q, rd_id_d;
  logic [OW-1:0]   rd_off_q, rd_off_d;
  logic [CW-1:0]   rd_ocnt_q, rd_ocnt_d;
  logic            rd_vld_q, rd_vld_d;
  logic            w_rd_done, w_rd_rel;

  logic [1:0]        w_tag;
  logic              w_head, w_body, w_is_tail, w_body_fits, w_verdict, w_bad;
  logic              w_keep, w_wr_drop, w_wr_rel, w_any_free, w_alloc;
  logic [ID_W-1:0]   w_alloc_id;
  logic              w_ram_we, w_out_tail;
  logic [AW-1:0]     w_wr_addr, w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;

  // Lowest-index free slot
  always_comb begin
    w_alloc_id = '0;
    for (int i = SLOT_NUM - 1; i >= 0; i--) begin
      if (free_q[i]) w_alloc_id = ID_W'(i);
    end
  end

  always_comb begin
    out_free_cnt = '0;
    for (int i = 0; i < SLOT_NUM; i++) begin
      out_free_cnt = out_free_cnt + (ID_W+1)'(free_q[i]);
    end
  end

  // ---------------------------------------------------------------- write side
  assign w_tag       = in_data[DATA_W-1 -: 2];
  assign w_any_free  = |free_q;
  assign w_head      = in_data_wr && (w_tag == HEAD);
  // Continuation cells only count while a packet is open and before its tail
  assign w_body      = in_data_wr && ((w_tag == MID) || (w_tag == TAIL)) && open_q && !tail_seen_q;
  assign w_is_tail   = w_body && (w_tag == TAIL);
  assign w_body_fits = w_body && has_slot_q && (wr_cnt_q < CW'(CELL_NUM));
  assign w_verdict   = in_valid_wr && open_q && (tail_seen_q || w_is_tail);
  assign w_bad       = ovf_q || (w_body && has_slot_q && !w_body_fits);
  assign w_keep      = w_verdict && in_valid && has_slot_q && !w_bad;
  // A head arriving before the verdict aborts the pending packet
  assign w_wr_drop   = (w_verdict && !w_keep) || (w_head && open_q && !w_verdict);
  assign w_wr_rel    = w_wr_drop && has_slot_q;
  assign w_alloc     = w_head && w_any_free;

  assign w_ram_we  = w_alloc || w_body_fits;
  assign w_wr_addr = w_head ? {w_alloc_id, {OW{1'b0}}} : {wr_id_q, wr_cnt_q[OW-1:0]};

  always_comb begin
    open_d      = open_q;
    tail_seen_d = tail_seen_q;
    has_slot_d  = has_slot_q;
    ovf_d       = ovf_q;
    wr_id_d     = wr_id_q;
    wr_cnt_d    = wr_cnt_q;
    if (w_verdict) open_d = 1'b0;
    if (w_head) begin
      open_d      = 1'b1;
      tail_seen_d = 1'b0;
      ovf_d       = 1'b0;
      has_slot_d  = w_any_free;
      wr_id_d     = w_alloc_id;
      wr_cnt_d    = w_any_free ? CW'(1) : '0;
    end else begin
      if (w_is_tail) tail_seen_d = 1'b1;
      if (w_body_fits) wr_cnt_d = wr_cnt_q + CW'(1);
      else if (w_body && has_slot_q) ovf_d = 1'b1;
    end
    id_wr_d = w_keep;
    id_d    = w_keep ? wr_id_q : id_q;
    drop_d  = (w_wr_drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
  end

  // ----------------------------------------------------------------- read side
  assign w_rd_addr = {rd_id_q, rd_off_q};
  // The stored length bounds the read even if a tail tag were missing
  assign w_out_tail = rd_vld_q && ((w_rd_data[DATA_W-1 -: 2] == TAIL) ||
                                   ((rd_ocnt_q + CW'(1)) == len_q[rd_id_q]));

  always_comb begin
    state_d   = state_q;
    rd_id_d   = rd_id_q;
    rd_off_d  = rd_off_q;
    rd_ocnt_d = rd_ocnt_q;
    rd_vld_d  = 1'b0;
    w_rd_done = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (in_id_wr && commit_q[in_id]) begin
          state_d   = RD_RD;
          rd_id_d   = in_id;
          rd_off_d  = '0;
          rd_ocnt_d = '0;
        end
      end
      RD_RD: begin
        rd_off_d = rd_off_q + OW'(1);
        if (rd_vld_q) rd_ocnt_d = rd_ocnt_q + CW'(1);
        if (w_out_tail) state_d = RD_LAST;
        else            rd_vld_d = 1'b1;
      end
      RD_LAST: begin
        w_rd_done = 1'b1;
        state_d   = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

`ifdef PKT_CACHE_MCAST_EN
  logic [3:0] ref_q [SLOT_NUM];
  assign w_rd_rel = w_rd_done && (ref_q[rd_id_q] <= 4'd1);
  always_ff @(posedge clk) begin
    if (w_keep) ref_q[wr_id_q] <= (in_ref == 4'd0) ? 4'd1 : in_ref;
    if (w_rd_done && (ref_q[rd_id_q] > 4'd1)) ref_q[rd_id_q] <= ref_q[rd_id_q] - 4'd1;
  end
`else
  assign w_rd_rel = w_rd_done;
`endif

  // Releases from both sides merge with the allocation; an allocated ID comes
  // from the current free set, so a released ID is reusable next cycle.
  always_comb begin
    w_rel_mask   = '0;
    w_alloc_mask = '0;
    if (w_wr_rel) w_rel_mask[wr_id_q]   = 1'b1;
    if (w_rd_rel) w_rel_mask[rd_id_q]   = 1'b1;
    if (w_alloc)  w_alloc_mask[w_alloc_id] = 1'b1;
    free_d   = (free_q | w_rel_mask) & ~w_alloc_mask;
    commit_d = commit_q & ~w_rel_mask;
    if (w_keep) commit_d[wr_id_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_is_tail && w_body_fits) len_q[wr_id_q] <= wr_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_q      <= '1;
      commit_q    <= '0;
      open_q      <= 1'b0;
      tail_seen_q <= 1'b0;
      has_slot_q  <= 1'b0;
      ovf_q       <= 1'b0;
      wr_id_q     <= '0;
      wr_cnt_q    <= '0;
      id_wr_q     <= 1'b0;
      id_q        <= '0;
      drop_q      <= '0;
      state_q     <= RD_IDLE;
      rd_id_q     <= '0;
      rd_off_q    <= '0;
      rd_ocnt_q   <= '0;
      rd_vld_q    <= 1'b0;
    end else begin
      free_q      <= free_d;
      commit_q    <= commit_d;
      open_q      <= open_d;
      tail_seen_q <= tail_seen_d;
      has_slot_q  <= has_slot_d;
      ovf_q       <= ovf_d;
      wr_id_q     <= wr_id_d;
      wr_cnt_q    <= wr_cnt_d;
      id_wr_q     <= id_wr_d;
      id_q        <= id_d;
      drop_q      <= drop_d;
      state_q     <= state_d;
      rd_id_q     <= rd_id_d;
      rd_off_q    <= rd_off_d;
      rd_ocnt_q   <= rd_ocnt_d;
      rd_vld_q    <= rd_vld_d;
    end
  end

  pkt_cache_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (SLOT_NUM * CELL_NUM),
    .AW     (AW)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (w_ram_we),
    .wr_addr_i (w_wr_addr),
    .wr_data_i (in_data),
    .rd_addr_i (w_rd_addr),
    .rd_data_o (w_rd_data)
  );

  assign out_id_wr    = id_wr_q;
  assign out_id       = id_q;
  assign out_drop_cnt = drop_q;
  assign in_id_rdy    = (state_q == RD_IDLE);
  assign out_data_wr  = rd_vld_q;
  assign out_data     = rd_vld_q ? w_rd_data : '0;
  assign out_valid_wr = (state_q == RD_LAST);
  assign out_valid    = (state_q == RD_LAST);

endmodule
`default_nettype wire

// File: tb/tb_pkt_cache.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pkt_cache                                                               |
// | Self-checking bench: directed scenarios plus a randomized phase, compared  |
// | against a slot-level reference model (free set, stored packets, drops).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pkt_cache;
  import pkt_cache_pkg::*;

  localparam int DW = DEF_DATA_W;
  localparam int SN = DEF_SLOT_NUM;
  localparam int CN = DEF_CELL_NUM;
  localparam int IW = $clog2(SN);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_data_wr, in_valid_wr, in_valid, in_id_wr;
  logic [DW-1:0] in_data;
  logic [IW-1:0] in_id;
  logic [3:0]    in_ref;
  logic          out_id_wr, in_id_rdy, out_data_wr, out_valid_wr, out_valid;
  logic [IW-1:0] out_id;
  logic [IW:0]   out_free_cnt;
  logic [DW-1:0] out_data;
  logic [15:0]   out_drop_cnt;

  initial forever #5 clk = ~clk;

  pkt_cache #(.DATA_W(DW), .SLOT_NUM(SN), .CELL_NUM(CN)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data_wr   (in_data_wr),
    .in_data      (in_data),
    .in_valid_wr  (in_valid_wr),
    .in_valid     (in_valid),
`ifdef PKT_CACHE_MCAST_EN
    .in_ref       (in_ref),
`endif
    .out_id_wr    (out_id_wr),
    .out_id       (out_id),
    .out_free_cnt (out_free_cnt),
    .in_id_wr     (in_id_wr),
    .in_id        (in_id),
    .in_id_rdy    (in_id_rdy),
    .out_data_wr  (out_data_wr),
    .out_data     (out_data),
    .out_valid_wr (out_valid_wr),
    .out_valid    (out_valid),
    .out_drop_cnt (out_drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: slot occupancy, committed contents, reference counts
  bit            m_used   [SN];
  bit            m_commit [SN];
  int            m_refs   [SN];
  logic [DW-1:0] m_pkt    [SN][$];
  int            m_drops;
  bit            pend;
  int            pend_slot;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_free_cnt();
    int n = 0;
    for (int i = 0; i < SN; i++) if (!m_used[i]) n++;
    return n;
  endfunction

  function automatic int m_lowest();
    for (int i = 0; i < SN; i++) if (!m_used[i]) return i;
    return -1;
  endfunction

  function automatic logic [DW-1:0] mk_cell(input logic [1:0] tg);
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return {tg, r[DW-3:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SN; i++) begin
      m_used[i] = 0; m_commit[i] = 0; m_refs[i] = 0; m_pkt[i].delete();
    end
    m_drops = 0; pend = 0; pend_slot = -1;
  endtask

  task automatic do_reset();
    in_data_wr = 0; in_valid_wr = 0; in_valid = 0; in_id_wr = 0;
    in_data = '0; in_id = '0; in_ref = 4'd1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    chk("rst_free", out_free_cnt, SN);
    chk("rst_drop", out_drop_cnt, 0);
    chk("rst_rdy", in_id_rdy, 1);
    chk("rst_strobes", {out_id_wr, out_data_wr, out_valid_wr, out_valid}, 0);
    chk("rst_data", out_data, 0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // gap < 0 leaves the packet waiting for a verdict
  task automatic send_pkt(input int n, input bit keep, input int gap, input int refv, output int id);
    logic [DW-1:0] tmp[$];
    bit got, kept;
    id  = m_lowest();
    got = (id >= 0);
    in_ref = 4'(refv);
    for (int i = 0; i < n; i++) begin
      logic [1:0] tg;
      tg = (i == 0) ? HEAD : ((i == n - 1) ? TAIL : MID);
      in_data_wr = 1; in_data = mk_cell(tg);
      if (got && i < CN) tmp.push_back(in_data);
      if (i == n - 1 && gap == 0) begin in_valid_wr = 1; in_valid = keep; end
      @(negedge clk);
      in_data_wr = 0; in_valid_wr = 0;
      if (i == 0) begin
        if (pend) begin
          m_drops++;
          if (pend_slot >= 0) m_used[pend_slot] = 0;
          pend = 0;
        end
        if (got) m_used[id] = 1;
        chk("free_after_head", out_free_cnt, m_free_cnt());
        chk("drop_after_head", out_drop_cnt, m_drops);
      end
    end
    if (gap > 0) begin
      repeat (gap - 1) @(negedge clk);
      in_valid_wr = 1; in_valid = keep;
      @(negedge clk);
      in_valid_wr = 0;
    end
    if (gap < 0) begin
      pend = 1; pend_slot = got ? id : -1;
      return;
    end
    kept = keep && got && (n <= CN);
    if (kept) begin
      chk("id_wr", out_id_wr, 1);
      chk("id", out_id, id);
      m_commit[id] = 1;
      m_pkt[id]    = tmp;
`ifdef PKT_CACHE_MCAST_EN
      m_refs[id] = (refv == 0) ? 1 : refv;
`else
      m_refs[id] = 1;
`endif
    end else begin
      chk("no_id_wr", out_id_wr, 0);
      m_drops++;
      if (got) m_used[id] = 0;
      id = -1;
    end
    chk("free_after_verdict", out_free_cnt, m_free_cnt());
    chk("drop_after_verdict", out_drop_cnt, m_drops);
  endtask

  task automatic read_pkt(input int id);
    bit ok;
    ok = m_commit[id];
    in_id_wr = 1; in_id = IW'(id);
    @(negedge clk);
    in_id_wr = 0;
    chk("rd_gap", out_data_wr, 0);
    chk("rd_rdy_busy", in_id_rdy, ok ? 0 : 1);
    @(negedge clk);
    if (!ok) begin
      chk("rd_ignored", out_data_wr, 0);
      chk("rd_ignored_free", out_free_cnt, m_free_cnt());
      return;
    end
    for (int k = 0; k < m_pkt[id].size(); k++) begin
      chk("rd_wr", out_data_wr, 1);
      chk("rd_data", out_data, m_pkt[id][k]);
      @(negedge clk);
    end
    chk("rd_end_wr", out_data_wr, 0);
    chk("rd_valid", {out_valid_wr, out_valid}, 2'b11);
    m_refs[id]--;
    if (m_refs[id] == 0) begin m_used[id] = 0; m_commit[id] = 0; end
    @(negedge clk);
    chk("rd_rdy", in_id_rdy, 1);
    chk("free_after_rd", out_free_cnt, m_free_cnt());
  endtask

  initial begin
    int id, a, f0, sel;
    bit seen;

    // Reset state, then one packet in and out
    do_reset();
    send_pkt(4, 1, 0, 1, id);
    chk("first_id", id, 0);
    chk("first_free", out_free_cnt, SN - 1);
    read_pkt(0);
    chk("first_free_back", out_free_cnt, SN);

    // Read of a free slot is ignored
    read_pkt(5);

    // Oversized packet is dropped and its slot freed
    send_pkt(130, 1, 1, 1, id);
    chk("ovf_drop", out_drop_cnt, 1);
    chk("ovf_free", out_free_cnt, SN);

    // Head before verdict aborts the pending packet
    send_pkt(3, 1, -1, 1, id);
    send_pkt(3, 1, 0, 1, a);
    chk("abort_drop", out_drop_cnt, 2);

    // Drop verdict in the same cycle a read releases another slot
    send_pkt(3, 1, -1, 1, id);
    f0 = m_free_cnt();
    in_id_wr = 1; in_id = IW'(a);
    @(negedge clk);
    in_id_wr = 0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (out_valid_wr) seen = 1;
      else @(negedge clk);
    end
    chk("dual_rel_seen", seen, 1);
    in_valid_wr = 1; in_valid = 0;
    @(negedge clk);
    in_valid_wr = 0;
    m_drops++; m_used[pend_slot] = 0; pend = 0;
    m_refs[a]--;
    if (m_refs[a] == 0) begin m_used[a] = 0; m_commit[a] = 0; end
    chk("dual_rel_free", out_free_cnt, f0 + 2);
    chk("dual_rel_drop", out_drop_cnt, m_drops);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        send_pkt(int'($urandom_range(2, 6)), ($urandom_range(0, 4) != 0),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), id);
      end else begin
        sel = int'($urandom_range(0, SN - 1));
        if ($urandom_range(0, 9) < 7) begin
          for (int j = 0; j < SN; j++) begin
            if (m_commit[(sel + j) % SN]) begin sel = (sel + j) % SN; break; end
          end
        end
        read_pkt(sel);
      end
    end

    // Fill every slot, then overflow the cache
    do_reset();
    for (int s = 0; s < SN; s++) begin
      send_pkt(2, 1, 0, 1, id);
      chk("fill_id", id, s);
    end
    send_pkt(2, 1, 0, 1, id);
    chk("full_drop", out_drop_cnt, 1);
    chk("full_free", out_free_cnt, 0);
    read_pkt(7);
    read_pkt(0);

`ifdef PKT_CACHE_MCAST_EN
    // Multicast: slot survives until its third read
    do_reset();
    send_pkt(3, 1, 0, 3, id);
    read_pkt(id);
    chk("mc_free1", out_free_cnt, SN - 1);
    read_pkt(id);
    chk("mc_free2", out_free_cnt, SN - 1);
    read_pkt(id);
    chk("mc_free3", out_free_cnt, SN);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
